// File: rtl/arb_param.sv
// -----------------------------------------------------------------------------
// arb_param
//   N-requester arbiter placed between N bus masters and one shared resource.
//   The arbitration scheme is selected at elaboration time:
//     * fixed priority (index 0 highest) or round robin;
//     * optional grant hold while the holder keeps requesting;
//     * an optional maximum hold length that forces re-arbitration.
//   The grant is registered and one-hot. There is no combinational path from
//   request to grant.
//
// Parameters
//   N        number of requesters (2..16)
//   MODE     0 = fixed priority, 1 = round robin
//   HOLD     1 = holder keeps grant while requesting, 0 = re-arbitrate each cycle
//   MAX_HOLD max consecutive cycles of one grant when HOLD=1 (0 = unlimited)
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   request      request vector, bit i = requester i
//   grant        registered one-hot grant, all-zero when idle
//   grant_valid  high when any grant bit is set
//   grant_id     index of the granted requester, 0 when idle
// -----------------------------------------------------------------------------
module arb_param #(
  parameter int N        = 4,
  parameter int MODE     = 1,
  parameter int HOLD     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);
  // With unlimited hold the counter value is never inspected; one bit keeps
  // the register legal.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] id_q,    id_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [HW-1:0] hold_q,  hold_d;

  logic          holder_req;
  logic          expired;
  logic          keep;
  logic [N-1:0]  cand;
  logic          found;
  logic [IW-1:0] winner;

  assign holder_req = valid_q && request[id_q];
  assign expired    = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1));
  assign keep       = holder_req && (HOLD != 0) && !expired;

  // An expired holder sits out one arbitration, unless nobody else is asking:
  // then it simply wins again with a fresh count.
  always_comb begin
    cand = request;
    if (holder_req && (HOLD != 0) && expired && ((request & ~grant_q) != '0)) begin
      cand = request & ~grant_q;
    end
  end

  // Winner selection. The first scan finds the lowest set index overall.
  // For round robin a second scan overrides it with the lowest set index at
  // or above ptr; if there is none, the first result is the wrapped winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found  = 1'b1;
        winner = IW'(i);
      end
    end
    if (MODE != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i] && (IW'(i) >= ptr_q)) begin
          winner = IW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (keep) begin
      hold_d = hold_q + 1'b1;
    end else if (!found) begin
      grant_d = '0;
      valid_d = 1'b0;
      id_d    = '0;
      hold_d  = '0;
    end else begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      valid_d         = 1'b1;
      id_d            = winner;
      hold_d          = '0;
      if (MODE != 0) begin
        ptr_d = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule
